// File: rtl/fpnew_f2icast_lanes.sv
// fpnew_f2icast_lanes: vectorial float-to-integer cast for the CONV group.
// One shared conversion datapath is walked over the packed lanes, one lane per
// cycle. The small package below carries the FPnew types this block uses.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   operands_i, lane_mask_i  packed FP operands / lane enables
//   rnd_mode_i, op_mod_i     rounding mode, 0=signed 1=unsigned
//   int_fmt_i, tag_i         destination integer format, operation tag
//   in_valid_i/in_ready_o    input handshake
//   flush_i                  kill in-flight operation
//   result_o, status_o       packed integer results, OR of lane flags
//   tag_o                    tag of the result at the output
//   out_valid_o/out_ready_i  output handshake
//   busy_o                   operation in flight
package fpnew_pkg;
  typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;
  localparam int unsigned NUM_INT_FORMATS = 4;
  typedef enum logic [1:0] {INT8, INT16, INT32, INT64} int_format_e;
  typedef logic [0:NUM_INT_FORMATS-1] ifmt_logic_t;
  typedef enum logic [2:0] {RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010,
                            RUP = 3'b011, RMM = 3'b100} roundmode_e;
  typedef struct packed {logic NV; logic DZ; logic OF; logic UF; logic NX;} status_t;

  function automatic int exp_bits(fp_format_e f);
    case (f)
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      default: return 8;
    endcase
  endfunction
  function automatic int man_bits(fp_format_e f);
    case (f)
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction
  function automatic int fp_width(fp_format_e f);
    return 1 + exp_bits(f) + man_bits(f);
  endfunction
  function automatic int int_width(int_format_e f);
    case (f)
      INT8:    return 8;
      INT16:   return 16;
      INT32:   return 32;
      default: return 64;
    endcase
  endfunction
  // Formats wider than the lane slot cannot be represented, so drop them.
  function automatic ifmt_logic_t ifmt_mask(ifmt_logic_t cfg, int unsigned w);
    ifmt_logic_t en;
    for (int i = 0; i < NUM_INT_FORMATS; i++)
      en[i] = cfg[i] && (int_width(int_format_e'(i)) <= int'(w));
    return en;
  endfunction
endpackage

// Single-lane converter: FP operand -> w-bit integer, sign-extended to IntWidth.
module fpnew_f2icast_conv import fpnew_pkg::*; #(
  parameter fp_format_e  SrcFpFormat = FP32,
  parameter int unsigned IntWidth    = 32,
  localparam int         FPW         = fp_width(SrcFpFormat)
) (
  input  logic [FPW-1:0]      i_fp,
  input  roundmode_e          i_rnd,
  input  logic                i_uns,
  input  logic [7:0]          i_w,
  output logic [IntWidth-1:0] o_res,
  output logic                o_nv,
  output logic                o_nx
);
  localparam int EB   = exp_bits(SrcFpFormat);
  localparam int MB   = man_bits(SrcFpFormat);
  localparam int BIAS = 2**(EB-1) - 1;
  localparam int WW   = MB + IntWidth + 2;   // fixed point: IntWidth+2 int bits, MB frac bits
  localparam int RW   = IntWidth + 2;

  logic          w_sign, w_nan, w_inf, w_huge, w_rb, w_sb, w_rup, w_ovf;
  logic [EB-1:0] w_exp;
  logic [MB-1:0] w_man;
  int            w_e, w_sh;
  logic [WW-1:0] w_word;
  logic [RW-1:0] w_ipart, w_mag, w_negm, w_lim;
  logic [IntWidth-1:0] w_raw, w_tmp;

  assign w_sign = i_fp[FPW-1];
  assign w_exp  = i_fp[FPW-2 -: EB];
  assign w_man  = i_fp[MB-1:0];
  assign w_nan  = (&w_exp) & (|w_man);
  assign w_inf  = (&w_exp) & ~(|w_man);
  assign w_e    = int'(w_exp) - BIAS;
  // Beyond IntWidth the value overflows every format, so skip the shift.
  assign w_huge = w_e > int'(IntWidth);

  always_comb begin
    w_word  = '0;
    w_ipart = '0;
    w_rb    = 1'b0;
    w_sb    = 1'b0;
    if (w_e >= 0) begin
      if (!w_huge) w_word = {{(IntWidth+1){1'b0}}, 1'b1, w_man} << w_e;
      w_ipart = w_word[WW-1:MB];
      w_rb    = w_word[MB-1];
      w_sb    = |w_word[MB-2:0];
    end else if (w_e == -1) begin
      // 0.5 <= |x| < 1: the hidden one is exactly the round bit
      w_rb = 1'b1;
      w_sb = |w_man;
    end else begin
      // |x| < 0.5 incl. subnormals: only stickiness survives
      w_sb = (|w_exp) | (|w_man);
    end

    case (i_rnd)
      RNE:     w_rup = w_rb & (w_sb | w_ipart[0]);
      RDN:     w_rup = w_sign & (w_rb | w_sb);
      RUP:     w_rup = ~w_sign & (w_rb | w_sb);
      RMM:     w_rup = w_rb;
      default: w_rup = 1'b0;
    endcase
    w_mag  = w_ipart + {{(RW-1){1'b0}}, w_rup};
    w_negm = -w_mag;
    w_lim  = {{(RW-1){1'b0}}, 1'b1} << (i_w - 8'd1);   // 2^(w-1)

    // Range check on the rounded magnitude; -2^(w-1) is legal when signed.
    if (i_uns) w_ovf = w_sign ? (w_mag != '0) : (w_mag >= (w_lim << 1));
    else       w_ovf = w_sign ? (w_mag > w_lim) : (w_mag >= w_lim);
    w_ovf = w_ovf | w_huge;

    if (w_nan || (!w_sign && (w_inf || w_ovf)))
      w_raw = i_uns ? '1 : (w_lim[IntWidth-1:0] - 1'b1);
    else if (w_inf || w_ovf)
      w_raw = i_uns ? '0 : w_lim[IntWidth-1:0];
    else
      w_raw = w_sign ? w_negm[IntWidth-1:0] : w_mag[IntWidth-1:0];

    o_nv = w_nan | w_inf | w_ovf;
    o_nx = ~o_nv & (w_rb | w_sb);

    // Sign-extend from bit w-1 into the full slot.
    w_sh  = int'(IntWidth) - int'(i_w);
    w_tmp = w_raw << w_sh;
    o_res = $signed(w_tmp) >>> w_sh;
  end
endmodule

module fpnew_f2icast_lanes import fpnew_pkg::*; #(
  parameter fp_format_e  SrcFpFormat  = FP32,
  parameter int unsigned NumLanes     = 4,
  parameter int unsigned IntWidth     = 32,
  parameter ifmt_logic_t IntFmtConfig = '1,
  parameter type         TagType      = logic,
  localparam int         SRC_WIDTH    = fp_width(SrcFpFormat)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumLanes*SRC_WIDTH-1:0] operands_i,
  input  logic [NumLanes-1:0]          lane_mask_i,
  input  roundmode_e                   rnd_mode_i,
  input  logic                         op_mod_i,
  input  int_format_e                  int_fmt_i,
  input  TagType                       tag_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic                         flush_i,
  output logic [NumLanes*IntWidth-1:0] result_o,
  output status_t                      status_o,
  output TagType                       tag_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         busy_o
);
  localparam ifmt_logic_t INT_FMT_EN = ifmt_mask(IntFmtConfig, IntWidth);
  localparam int          CNT_W      = (NumLanes > 1) ? $clog2(NumLanes) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e                                 r_state;
  logic [NumLanes-1:0][SRC_WIDTH-1:0]     r_ops;
  logic [NumLanes-1:0]                    r_mask;
  roundmode_e                             r_rnd;
  logic                                   r_mod;
  int_format_e                            r_fmt;
  TagType                                 r_tag;
  logic [NumLanes-1:0][IntWidth-1:0]      r_res;
  status_t                                r_status;
  logic [CNT_W-1:0]                       r_cnt;

  logic                w_accept, w_nv, w_nx;
  logic [7:0]          w_w;
  logic [IntWidth-1:0] w_res;

  assign in_ready_o  = (r_state == IDLE) | ((r_state == DONE) & out_ready_i);
  assign w_accept    = in_valid_i & in_ready_o;
  assign out_valid_o = (r_state == DONE);
  assign busy_o      = (r_state != IDLE);
  assign result_o    = r_res;
  assign status_o    = r_status;
  assign tag_o       = r_tag;

  // Disabled formats fall back to the slot width; the result is don't-care.
  assign w_w = INT_FMT_EN[r_fmt] ? 8'(int_width(r_fmt)) : 8'(IntWidth);

  fpnew_f2icast_conv #(.SrcFpFormat(SrcFpFormat), .IntWidth(IntWidth)) u_conv (
    .i_fp (r_ops[r_cnt]),
    .i_rnd(r_rnd),
    .i_uns(r_mod),
    .i_w  (w_w),
    .o_res(w_res),
    .o_nv (w_nv),
    .o_nx (w_nx)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_ops    <= '0;
      r_mask   <= '0;
      r_rnd    <= RNE;
      r_mod    <= 1'b0;
      r_fmt    <= INT8;
      r_tag    <= '0;
      r_res    <= '0;
      r_status <= '0;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_state <= IDLE;
    end else if (w_accept) begin
      // Accept happens only from IDLE or on the DONE handshake.
      r_state  <= CONV;
      r_ops    <= operands_i;
      r_mask   <= lane_mask_i;
      r_rnd    <= rnd_mode_i;
      r_mod    <= op_mod_i;
      r_fmt    <= int_fmt_i;
      r_tag    <= tag_i;
      r_res    <= '0;
      r_status <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        CONV: begin
          r_res[r_cnt] <= r_mask[r_cnt] ? w_res : '0;
          if (r_mask[r_cnt]) begin
            r_status.NV <= r_status.NV | w_nv;
            r_status.NX <= r_status.NX | w_nx;
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(NumLanes-1)) r_state <= DONE;
        end
        DONE:    if (out_ready_i) r_state <= IDLE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpnew_f2icast_lanes.sv
module tb_fpnew_f2icast_lanes;
  import fpnew_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] operands;
  logic [3:0]   lane_mask;
  roundmode_e   rnd_mode;
  logic         op_mod;
  int_format_e  int_fmt;
  logic         tag_in;
  logic         in_valid, in_ready, flush;
  logic [127:0] result;
  status_t      status;
  logic         tag_out;
  logic         out_valid, out_ready, busy;

  int n_checks = 0;
  int n_fail   = 0;

  fpnew_f2icast_lanes dut (
    .clk_i(clk), .rst_ni(rst_n), .operands_i(operands), .lane_mask_i(lane_mask),
    .rnd_mode_i(rnd_mode), .op_mod_i(op_mod), .int_fmt_i(int_fmt), .tag_i(tag_in),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .flush_i(flush),
    .result_o(result), .status_o(status), .tag_o(tag_out),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] OPS_A = {32'h4F32D05E, 32'h7FC00000, 32'hBFC00000, 32'h40200000};
  localparam logic [127:0] OPS_R = {32'hBF000000, 32'h3F000000, 32'hC0200000, 32'h40200000};

  // Drives one operation in the cycle before a posedge; returns at the
  // following negedge with in_valid dropped.
  task automatic start_op(input logic [127:0] ops, input logic [3:0] mask, input roundmode_e rm,
                          input logic md, input int_format_e fmt, input logic tg);
    @(negedge clk);
    operands = ops; lane_mask = mask; rnd_mode = rm; op_mod = md; int_fmt = fmt; tag_in = tg;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts posedges from the accept edge (inclusive) until out_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl got valid=%b busy=%b exp 0 0", out_valid, busy);
    end
    n_checks++;
    if (result !== 128'h0 || status !== 5'b0 || tag_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_data got res=%h st=%b tag=%b exp 0", result, status, tag_out);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_signed_rne();
    int lat;
    start_op(OPS_A, 4'b1111, RNE, 1'b0, INT32, 1'b1);
    wait_valid(lat);
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL s_rne_latency got %0d exp 5", lat); end
    n_checks++;
    if (result !== {32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'h00000002}) begin
      n_fail++; $display("FAIL s_rne_result got %h", result);
    end
    n_checks++;
    if (status !== 5'b10001 || tag_out !== 1'b1) begin
      n_fail++; $display("FAIL s_rne_status got st=%b tag=%b exp 10001 1", status, tag_out);
    end
    retire();
  endtask

  task automatic test_unsigned_rtz();
    int lat;
    start_op(OPS_A, 4'b1111, RTZ, 1'b1, INT32, 1'b0);
    wait_valid(lat);
    n_checks++;
    if (result !== {32'hB2D05E00, 32'hFFFFFFFF, 32'h00000000, 32'h00000002} || lat !== 5) begin
      n_fail++; $display("FAIL u_rtz_result got %h lat=%0d", result, lat);
    end
    n_checks++;
    if (status !== 5'b10001) begin n_fail++; $display("FAIL u_rtz_status got %b exp 10001", status); end
    retire();
  endtask

  task automatic test_neg_small_masked();
    int lat;
    // masked-off lanes carry NaNs that must leave no trace
    start_op({32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'hBE99999A}, 4'b0001, RTZ, 1'b1, INT32, 1'b1);
    wait_valid(lat);
    n_checks++;
    if (result !== 128'h0 || status !== 5'b00001) begin
      n_fail++; $display("FAIL neg_small got res=%h st=%b exp 0 00001", result, status);
    end
    retire();
  endtask

  task automatic test_round_modes();
    int lat;
    start_op(OPS_R, 4'b1111, RUP, 1'b0, INT32, 1'b0);
    wait_valid(lat);
    n_checks++;
    if (result !== {32'h00000000, 32'h00000001, 32'hFFFFFFFE, 32'h00000003} || status !== 5'b00001) begin
      n_fail++; $display("FAIL rup got %h st=%b", result, status);
    end
    retire();
    start_op(OPS_R, 4'b1111, RDN, 1'b0, INT32, 1'b0);
    wait_valid(lat);
    n_checks++;
    if (result !== {32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFD, 32'h00000002}) begin
      n_fail++; $display("FAIL rdn got %h", result);
    end
    retire();
    start_op(OPS_R, 4'b1111, RMM, 1'b0, INT32, 1'b0);
    wait_valid(lat);
    n_checks++;
    if (result !== {32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFD, 32'h00000003}) begin
      n_fail++; $display("FAIL rmm got %h", result);
    end
    retire();
  endtask

  task automatic test_int8();
    int lat;
    start_op({96'h0, 32'h43000000}, 4'b0001, RNE, 1'b0, INT8, 1'b0);
    wait_valid(lat);
    n_checks++;
    if (result !== {96'h0, 32'h0000007F} || status !== 5'b10000) begin
      n_fail++; $display("FAIL int8_pos_ovf got %h st=%b exp 7f 10000", result, status);
    end
    retire();
    start_op({96'h0, 32'hC3000000}, 4'b0001, RNE, 1'b0, INT8, 1'b0);
    wait_valid(lat);
    n_checks++;
    if (result !== {96'h0, 32'hFFFFFF80} || status !== 5'b00000) begin
      n_fail++; $display("FAIL int8_min got %h st=%b exp ffffff80 00000", result, status);
    end
    retire();
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(OPS_A, 4'b1111, RNE, 1'b0, INT32, 1'b1);
    wait_valid(lat);
    n_checks++;
    if (tag_out !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first got tag=%b rdy=%b exp 1 0", tag_out, in_ready);
    end
    // second op presented during the output handshake
    operands = {96'h0, 32'hC3000000}; lane_mask = 4'b0001; int_fmt = INT8; tag_in = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept got busy=%b valid=%b exp 1 0", busy, out_valid);
    end
    wait_valid(lat);
    n_checks++;
    if (lat !== 5 || tag_out !== 1'b0 || result !== {96'h0, 32'hFFFFFF80}) begin
      n_fail++; $display("FAIL b2b_second got lat=%0d tag=%b res=%h", lat, tag_out, result);
    end
    retire();
  endtask

  task automatic test_backpressure();
    int lat, bad;
    bad = 0;
    start_op({96'h0, 32'h43000000}, 4'b0001, RNE, 1'b0, INT8, 1'b1);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      operands = OPS_A; lane_mask = 4'b1111; in_valid = 1'b1;   // must be ignored
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== {96'h0, 32'h0000007F} ||
          status !== 5'b10000 || tag_out !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL backpressure got %0d bad cycles exp 0", bad); end
    retire();
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_retire got busy=%b valid=%b exp 0 0", busy, out_valid);
    end
  endtask

  task automatic test_flush();
    int seen;
    seen = 0;
    start_op(OPS_A, 4'b1111, RNE, 1'b0, INT32, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_conv got busy=%b valid=%b rdy=%b exp 0 0 1", busy, out_valid, in_ready);
    end
    // flush wins over an accept in the same cycle
    operands = OPS_A; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_accept got busy=%b exp 0", busy); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL flush_no_valid got %0d valid cycles exp 0", seen); end
  endtask

  task automatic test_async_reset();
    start_op(OPS_A, 4'b1111, RNE, 1'b0, INT32, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 128'h0 || status !== 5'b0 || tag_out !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got valid=%b busy=%b res=%h st=%b tag=%b",
                         out_valid, busy, result, status, tag_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_rdy got %b exp 1", in_ready); end
  endtask

  initial begin
    rst_n = 1'b0; operands = '0; lane_mask = '0; rnd_mode = RNE; op_mod = 1'b0;
    int_fmt = INT32; tag_in = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_signed_rne();
    test_unsigned_rtz();
    test_neg_small_masked();
    test_round_modes();
    test_int8();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fpnew_f2icast_lanes.md
Name: fpnew_f2icast_lanes

Overview:
- Vectorial float-to-integer converter for the FPnew CONV operation group.
- Converts up to NumLanes packed floating-point operands of format SrcFpFormat to integers of a selectable width.
- A single shared conversion datapath is time-multiplexed over the lanes, one lane per cycle, under a small FSM with valid/ready handshakes, flush and tag passthrough.
- Trades throughput for area versus a fully parallel, one-datapath-per-lane cast.

Parameters:
- SrcFpFormat, fpnew_pkg::FP32: source FP format of every lane.
- NumLanes, 4: number of packed lanes; must be ≥ 1.
- IntWidth, 32: per-lane destination slot width; must be ≥ int_width of every format enabled in IntFmtConfig.
- IntFmtConfig, '{default: 1'b1} masked to formats ≤ IntWidth: enabled integer formats.
- TagType, logic: type of the tag passed alongside each operation.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- operands_i  in  NumLanes*SRC_WIDTH  packed FP operands; lane k occupies bits [k*SRC_WIDTH +: SRC_WIDTH].
- lane_mask_i  in  NumLanes  lane enable.
- rnd_mode_i  in  roundmode_e  RNE/RTZ/RDN/RUP/RMM.
- op_mod_i  in  1  0 = signed conversion, 1 = unsigned conversion.
- int_fmt_i  in  int_format_e  destination integer format.
- tag_i  in  TagType  operation tag.
- in_valid_i  in  1  input handshake valid.
- in_ready_o  out  1  input handshake ready.
- flush_i  in  1  kills the in-flight operation.
- result_o  out  NumLanes*IntWidth  packed integer results, same lane packing as operands_i.
- status_o  out  status_t  status flags, OR over all enabled lanes.
- tag_o  out  TagType  tag of the operation at the output.
- out_valid_o  out  1  output handshake valid.
- out_ready_i  in  1  output handshake ready.
- busy_o  out  1  operation in flight.

Behaviour:
- FSM states: IDLE, CONV, DONE. Reset state is IDLE.
- Reset values: out_valid_o=0, busy_o=0, result_o=0, status_o=0, tag_o=0. in_ready_o=1 once reset deasserts.
- Input accept:
  - in_ready_o = IDLE | (DONE & out_ready_i).
  - An operation is accepted when in_valid_i & in_ready_o.
  - On accept, latch operands, mask, rnd_mode, op_mod, int_fmt and tag; clear the result and status registers; set lane counter = 0; go to CONV.
- CONV state:
  - Each cycle converts lane [counter]. Enabled lanes write their result slot and OR their flags into status. Disabled lanes write 0 and contribute no flags.
  - Counter increments every cycle. After lane NumLanes-1 is written, go to DONE.
- DONE state:
  - out_valid_o=1 with result, status and tag held stable until out_ready_i.
  - On handshake: go to CONV if a new operation is accepted in the same cycle, else go to IDLE.
- Timing: latency from accept to out_valid_o is NumLanes+1 cycles. Sustained throughput is one operation per NumLanes+1 cycles.
- busy_o = (state != IDLE).
- flush_i:
  - Synchronous: next state is IDLE and out_valid_o=0.
  - Any in-flight operation is discarded, including one being accepted in the same cycle.
  - flush_i has priority over all handshakes.
- Per-lane conversion, with w = int_width(int_fmt):
  - Exact value is rounded per rnd_mode.
  - Subnormals and any |x|<1 round to 0 or ±1.
  - NX is set when the result is inexact.
- Special cases (all set NV only, never NX):
  - NaN → signed 2^(w-1)-1, unsigned 2^w-1.
  - +Inf or positive overflow → same values as NaN.
  - -Inf or negative overflow → signed -2^(w-1), unsigned 0.
  - Negative input converted unsigned whose rounded magnitude is nonzero → 0.
- Overflow range:
  - Signed range: input exponent ≥ w-1, except -2^(w-1) exactly, which is legal.
  - Unsigned range extends one exponent higher.
  - Overflow is evaluated after rounding.
- Slot filling: every lane result is sign-extended from bit w-1 to IntWidth, for both signed and unsigned conversion.
- Illegal int_fmt (format not enabled): the result is undefined but the handshake must still complete.

Test Plan:
- FP32, NumLanes=4, int_fmt=INT32, signed, RNE; lanes {0x40200000 (2.5), 0xBFC00000 (-1.5), 0x7FC00000 (NaN), 0x4F32D05E (3e9)}, mask=1111 → lanes {0x2, 0xFFFFFFFE, 0x7FFFFFFF, 0x7FFFFFFF}; status NV=1, NX=1; out_valid_o exactly 5 cycles after accept.
- Same operands, unsigned, RTZ → lane0=0x2, lane1=0x00000000, lane2=0xFFFFFFFF, lane3=0xB2D05E00; status NV=1, NX=1.
- 0xBE99999A (-0.3), unsigned, RTZ, mask=0001 → 0, NV=0, NX=1; lanes 1-3 = 0.
- int_fmt=INT8, signed, 0x43000000 (128.0) → 0x0000007F, NV. With 0xC3000000 (-128.0) → 0xFFFFFF80, no flags.
- Back-to-back: hold out_ready_i=1 and present a second op while in DONE → second op accepted in the handshake cycle, its out_valid_o 5 cycles later, tags preserved in order.
- Backpressure and flush:
  - out_ready_i=0 for 10 cycles → outputs stable, in_ready_o=0.
  - Assert flush_i mid-CONV → IDLE next cycle, out_valid_o never rises for that op, busy_o=0.
  - Assert rst_ni low mid-CONV → all outputs back to reset values immediately.
